// File: rtl/parking_gate_sensor.sv
// Parking gate beam sensor: two photo-beams, synchronized and debounced,
// feed a direction FSM that pulses entry/exit on a completed passage and
// fault on a timeout or an impossible beam sequence.
module parking_gate_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beam_a,
  input  logic beam_b,
  output logic entry,
  output logic exit,
  output logic busy,
  output logic fault
);

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLR
  } state_t;

  logic [1:0]  raw;
  logic [1:0]  filt;
  logic        fa;
  logic        fb;
  logic [1:0]  pat;
  state_t      state_reg;
  logic [15:0] dwell_reg;
  logic        in_passage;

  assign raw = {beam_b, beam_a};
  assign fa  = filt[0];
  assign fb  = filt[1];
  assign pat = {fa, fb};

  // A state between IDLE and WAIT_CLR means a car is somewhere in the gate.
  assign in_passage = (state_reg != IDLE) && (state_reg != WAIT_CLR);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_beam
      logic       s1_reg;
      logic       s2_reg;
      logic       f_reg;
      logic [7:0] cnt_reg;

      // Two-flop synchronizer, then accept a change only after it has held
      // for DEBOUNCE consecutive cycles; any return to the old value restarts.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          f_reg   <= 1'b0;
          cnt_reg <= 8'd0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == f_reg) begin
            cnt_reg <= 8'd0;
          end else if (cnt_reg == DB_LAST) begin
            f_reg   <= s2_reg;
            cnt_reg <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      end

      assign filt[gi] = f_reg;
    end
  endgenerate

  // Direction FSM with dwell timeout; outputs are registered alongside the
  // state so pulses appear in the cycle after the transition is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dwell_reg <= 16'd0;
      entry     <= 1'b0;
      exit      <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      entry <= 1'b0;
      exit  <= 1'b0;
      fault <= 1'b0;
      if (in_passage && (dwell_reg != 16'hFFFF)) begin
        dwell_reg <= dwell_reg + 16'd1;
      end
      if (in_passage && (dwell_reg == TO_LAST)) begin
        // Timeout wins over any pattern seen this cycle: the passage is void.
        state_reg <= WAIT_CLR;
        busy      <= 1'b1;
        fault     <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            case (pat)
              2'b10:   begin state_reg <= IN1;      busy <= 1'b1; dwell_reg <= 16'd0; end
              2'b01:   begin state_reg <= OUT1;     busy <= 1'b1; dwell_reg <= 16'd0; end
              2'b11:   begin state_reg <= WAIT_CLR; busy <= 1'b1; fault <= 1'b1;      end
              default: ;
            endcase
          end
          IN1: begin
            case (pat)
              2'b11:   state_reg <= IN2;
              2'b00:   begin state_reg <= IDLE;     busy <= 1'b0;  end
              2'b01:   begin state_reg <= WAIT_CLR; fault <= 1'b1; end
              default: ;
            endcase
          end
          IN2: begin
            case (pat)
              2'b01:   state_reg <= IN3;
              2'b10:   state_reg <= IN1;
              2'b00:   begin state_reg <= WAIT_CLR; fault <= 1'b1; end
              default: ;
            endcase
          end
          IN3: begin
            case (pat)
              2'b00:   begin state_reg <= IDLE;     busy <= 1'b0; entry <= 1'b1; end
              2'b11:   state_reg <= IN2;
              2'b10:   begin state_reg <= WAIT_CLR; fault <= 1'b1; end
              default: ;
            endcase
          end
          OUT1: begin
            case (pat)
              2'b11:   state_reg <= OUT2;
              2'b00:   begin state_reg <= IDLE;     busy <= 1'b0;  end
              2'b10:   begin state_reg <= WAIT_CLR; fault <= 1'b1; end
              default: ;
            endcase
          end
          OUT2: begin
            case (pat)
              2'b10:   state_reg <= OUT3;
              2'b01:   state_reg <= OUT1;
              2'b00:   begin state_reg <= WAIT_CLR; fault <= 1'b1; end
              default: ;
            endcase
          end
          OUT3: begin
            case (pat)
              2'b00:   begin state_reg <= IDLE;     busy <= 1'b0; exit <= 1'b1; end
              2'b11:   state_reg <= OUT2;
              2'b01:   begin state_reg <= WAIT_CLR; fault <= 1'b1; end
              default: ;
            endcase
          end
          WAIT_CLR: begin
            if (pat == 2'b00) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_sensor.sv
// Bench for parking_gate_sensor: two instances (long and short timeout)
// share the beams; a behavioural model predicts every output each cycle and
// directed scenarios pin pulse counts and latencies with literal values.
module tb_parking_gate_sensor;

  localparam int DB = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic beam_a = 1'b0;
  logic beam_b = 1'b0;
  logic [1:0] entry_w, exit_w, busy_w, fault_w;
  logic [1:0] fa_w, fb_w;

  parking_gate_sensor #(.DEBOUNCE(DB), .TIMEOUT(1000)) dut0 (
    .clk(clk), .rst_n(rst_n), .beam_a(beam_a), .beam_b(beam_b),
    .entry(entry_w[0]), .exit(exit_w[0]), .busy(busy_w[0]), .fault(fault_w[0])
  );
  parking_gate_sensor #(.DEBOUNCE(DB), .TIMEOUT(50)) dut1 (
    .clk(clk), .rst_n(rst_n), .beam_a(beam_a), .beam_b(beam_b),
    .entry(entry_w[1]), .exit(exit_w[1]), .busy(busy_w[1]), .fault(fault_w[1])
  );

  assign fa_w = {dut1.fa, dut0.fa};
  assign fb_w = {dut1.fb, dut0.fb};

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int raw_cyc = 0;

  // observed pulse statistics, cleared per scenario
  int n_entry[2], n_exit[2], n_fault[2], n_busy[2], n_fa[2];
  int last_entry_cyc[2], last_exit_cyc[2], last_fault_cyc[2];

  // behavioural model state
  bit [1:0]    mdl[2][2];   // raw history: [0] one edge ago, [1] two edges ago
  bit [DB-1:0] mwin[2][2];  // last DB synchronized samples
  bit          mf[2][2];    // filtered beams
  int          mdir[2];     // 0 none, 1 inbound, 2 outbound
  int          mstage[2];   // progress 1..3 along the passage
  int          mdwell[2];
  bit          mwait[2];
  bit          e_entry[2], e_exit[2], e_fault[2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int to_of(input int i);
    return (i == 0) ? 1000 : 50;
  endfunction

  // Position along a passage: leading beam only, both, trailing only, none.
  function automatic int stage_of(input int d, input bit a, input bit b);
    bit p, q;
    p = (d == 1) ? a : b;
    q = (d == 1) ? b : a;
    if (p && !q) return 1;
    if (p && q)  return 2;
    if (!p && q) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 2; b++) begin
        mdl[i][b]  = '0;
        mwin[i][b] = '0;
        mf[i][b]   = 1'b0;
      end
      mdir[i] = 0; mstage[i] = 0; mdwell[i] = 0; mwait[i] = 1'b0;
      e_entry[i] = 1'b0; e_exit[i] = 1'b0; e_fault[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit a, b, smp, rb;
      int t, d;
      a = mf[i][0];
      b = mf[i][1];
      e_entry[i] = 1'b0; e_exit[i] = 1'b0; e_fault[i] = 1'b0;
      if (mwait[i]) begin
        if (!a && !b) mwait[i] = 1'b0;
      end else if (mdir[i] == 0) begin
        if (a && !b)      begin mdir[i] = 1; mstage[i] = 1; mdwell[i] = 0; end
        else if (!a && b) begin mdir[i] = 2; mstage[i] = 1; mdwell[i] = 0; end
        else if (a && b)  begin mwait[i] = 1'b1; e_fault[i] = 1'b1; end
      end else begin
        if (mdwell[i] == to_of(i) - 1) begin
          mdir[i] = 0; mwait[i] = 1'b1; e_fault[i] = 1'b1;
        end else begin
          t = stage_of(mdir[i], a, b);
          d = (t - mstage[i] + 4) % 4;
          if (d == 2) begin
            mdir[i] = 0; mwait[i] = 1'b1; e_fault[i] = 1'b1;
          end else if (t == 0) begin
            if (d == 1) begin
              if (mdir[i] == 1) e_entry[i] = 1'b1;
              else              e_exit[i]  = 1'b1;
            end
            mdir[i] = 0;
          end else begin
            mstage[i] = t;
          end
        end
        if (mdwell[i] < 65535) mdwell[i]++;
      end
      for (int k = 0; k < 2; k++) begin
        rb  = (k == 0) ? beam_a : beam_b;
        smp = mdl[i][k][1];
        mwin[i][k] = {mwin[i][k][DB-2:0], smp};
        if (mwin[i][k] == {DB{~mf[i][k]}}) mf[i][k] = ~mf[i][k];
        mdl[i][k] = {mdl[i][k][0], rb};
      end
    end
  endtask

  // Per-cycle compare against the model, plus pulse bookkeeping.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) model_reset();
      else        model_step();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("entry%0d", i), entry_w[i], e_entry[i]);
        chk($sformatf("exit%0d", i),  exit_w[i],  e_exit[i]);
        chk($sformatf("fault%0d", i), fault_w[i], e_fault[i]);
        chk($sformatf("busy%0d", i),  busy_w[i],  (mdir[i] != 0) || mwait[i]);
        chk($sformatf("fa%0d", i),    fa_w[i],    mf[i][0]);
        chk($sformatf("fb%0d", i),    fb_w[i],    mf[i][1]);
        chk($sformatf("onehot%0d", i), entry_w[i] & exit_w[i], 0);
        if (entry_w[i]) begin n_entry[i]++; last_entry_cyc[i] = cyc; end
        if (exit_w[i])  begin n_exit[i]++;  last_exit_cyc[i]  = cyc; end
        if (fault_w[i]) begin n_fault[i]++; last_fault_cyc[i] = cyc; end
        if (busy_w[i])  n_busy[i]++;
        if (fa_w[i])    n_fa[i]++;
      end
    end
  end

  task automatic set_beams(input bit a, input bit b);
    @(posedge clk);
    #2;
    beam_a  = a;
    beam_b  = b;
    raw_cyc = cyc;
    $display("cyc %0d: beam_a=%0d beam_b=%0d", cyc, a, b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_entry[i] = 0; n_exit[i] = 0; n_fault[i] = 0; n_busy[i] = 0; n_fa[i] = 0;
      last_entry_cyc[i] = 0; last_exit_cyc[i] = 0; last_fault_cyc[i] = 0;
    end
  endtask

  initial begin
    int t_last;
    int t_a;

    // reset state
    idle(2);
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("rst_entry", entry_w[i], 0);
      chk("rst_busy",  busy_w[i],  0);
      chk("rst_fault", fault_w[i], 0);
    end
    @(posedge clk); #3; rst_n = 1'b1;
    idle(5);

    // inbound car, 20 cycles per step
    clear_counts();
    set_beams(1, 0); idle(19);
    set_beams(1, 1); idle(19);
    set_beams(0, 1); idle(19);
    set_beams(0, 0); t_last = raw_cyc; idle(20);
    chk("in_entry_cnt",   n_entry[0], 1);
    chk("in_exit_cnt",    n_exit[0],  0);
    chk("in_fault_cnt",   n_fault[0], 0);
    chk("in_latency",     last_entry_cyc[0] - t_last, 7);
    chk("in_to50_entry",  n_entry[1], 0);
    chk("in_to50_fault",  n_fault[1], 1);
    $display("scenario inbound: entries=%0d latency=%0d", n_entry[0], last_entry_cyc[0] - t_last);

    // outbound car
    clear_counts();
    set_beams(0, 1); idle(19);
    set_beams(1, 1); idle(19);
    set_beams(1, 0); idle(19);
    set_beams(0, 0); t_last = raw_cyc; idle(20);
    chk("out_exit_cnt",  n_exit[0],  1);
    chk("out_entry_cnt", n_entry[0], 0);
    chk("out_fault_cnt", n_fault[0], 0);
    chk("out_latency",   last_exit_cyc[0] - t_last, 7);
    $display("scenario outbound: exits=%0d", n_exit[0]);

    // 3-cycle glitch on beam_a
    clear_counts();
    set_beams(1, 0); idle(2);
    set_beams(0, 0); idle(20);
    chk("gl_fa_cycles", n_fa[0],   0);
    chk("gl_busy",      n_busy[0], 0);
    chk("gl_pulses",    n_entry[0] + n_exit[0] + n_fault[0], 0);
    $display("scenario glitch: busy_cycles=%0d", n_busy[0]);

    // abort: A, AB, A, none
    clear_counts();
    set_beams(1, 0); idle(9);
    set_beams(1, 1); idle(9);
    set_beams(1, 0); idle(9);
    set_beams(0, 0); idle(20);
    chk("ab_pulses",    n_entry[0] + n_exit[0] + n_fault[0], 0);
    chk("ab_busy_cyc",  n_busy[0], 30);
    #3;
    chk("ab_busy_end",  busy_w[0], 0);
    $display("scenario abort: busy_cycles=%0d", n_busy[0]);

    // back-step chatter: A, AB, B, AB, B, none
    clear_counts();
    set_beams(1, 0); idle(7);
    set_beams(1, 1); idle(7);
    set_beams(0, 1); idle(7);
    set_beams(1, 1); idle(7);
    set_beams(0, 1); idle(7);
    set_beams(0, 0); idle(20);
    chk("bs_entry0", n_entry[0], 1);
    chk("bs_entry1", n_entry[1], 1);
    chk("bs_fault0", n_fault[0], 0);
    $display("scenario backstep: entries=%0d/%0d", n_entry[0], n_entry[1]);

    // timeout with beam_a held
    clear_counts();
    set_beams(1, 0); t_a = raw_cyc; idle(69);
    #3;
    chk("to_busy_wait", busy_w[1], 1);
    chk("to_busy_long", busy_w[0], 1);
    set_beams(0, 0); idle(20);
    chk("to_fault_cnt", n_fault[1], 1);
    chk("to_fault_cyc", last_fault_cyc[1] - t_a, 57);
    chk("to_entry",     n_entry[1], 0);
    chk("to_long_flt",  n_fault[0], 0);
    #3;
    chk("to_busy_end",  busy_w[1], 0);
    $display("scenario timeout: fault_at=+%0d", last_fault_cyc[1] - t_a);

    // illegal jump A only -> B only
    clear_counts();
    set_beams(1, 0); idle(9);
    set_beams(0, 1); idle(19);
    set_beams(0, 0); idle(20);
    chk("il_fault", n_fault[0], 1);
    chk("il_entry", n_entry[0], 0);
    chk("il_exit",  n_exit[0],  0);
    $display("scenario illegal: faults=%0d", n_fault[0]);

    // reset in IN3
    clear_counts();
    set_beams(1, 0); idle(9);
    set_beams(1, 1); idle(9);
    set_beams(0, 1); idle(9);
    #2;
    chk("rm_busy_pre", busy_w[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rm_busy",  busy_w[i],  0);
      chk("rm_entry", entry_w[i], 0);
      chk("rm_exit",  exit_w[i],  0);
      chk("rm_fault", fault_w[i], 0);
    end
    beam_a = 1'b0;
    beam_b = 1'b0;
    idle(3);
    @(posedge clk); #3; rst_n = 1'b1;
    clear_counts();
    idle(20);
    chk("rm_no_entry", n_entry[0] + n_entry[1], 0);
    chk("rm_no_busy",  n_busy[0], 0);
    $display("scenario reset-mid: entries=%0d", n_entry[0]);

    // beam_b held through reset becomes a fresh OUT1 after release
    @(posedge clk); #3; rst_n = 1'b0; beam_b = 1'b1;
    idle(2);
    @(posedge clk); #3; rst_n = 1'b1;
    clear_counts();
    idle(12);
    #3;
    chk("rh_busy", busy_w[0], 1);
    set_beams(0, 0); idle(20);
    chk("rh_exit", n_exit[0], 0);
    $display("scenario held-through-reset: busy_cycles=%0d", n_busy[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
